// File: rtl/spwm_gate_driver.sv
// Sawtooth-vs-reference comparator driving a complementary gate pair with
// programmable dead time; the reference is latched once per carrier period.
module spwm_gate_driver #(
   parameter int WIDTH = 10,
   parameter int DEAD  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] carrier,
   input  logic [WIDTH-1:0] ref_in,
   output logic             gate_hi,
   output logic             gate_lo,
   output logic             period_start
);

   localparam logic [7:0] DEAD_RELOAD = 8'(DEAD - 1);

   typedef enum logic [1:0] {
      S_OFF,
      S_DEAD,
      S_HI,
      S_LO
   } state_t;

   state_t           r_state;
   logic             r_target;
   logic [7:0]       r_dead_cnt;
   logic [WIDTH-1:0] r_carrier_d;
   logic [WIDTH-1:0] r_ref_hold;
   logic             r_raw_q;

   logic             w_wrap;
   logic [WIDTH-1:0] w_ref_eff;
   logic             w_raw;

   // The wrap cycle uses the live reference so the new period starts on it.
   assign w_wrap    = (carrier < r_carrier_d);
   assign w_ref_eff = w_wrap ? ref_in : r_ref_hold;
   assign w_raw     = (carrier < w_ref_eff);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_carrier_d  <= '0;
         r_ref_hold   <= '0;
         r_raw_q      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         r_carrier_d  <= carrier;
         period_start <= w_wrap;
         r_raw_q      <= w_raw;
         if (w_wrap) begin
            r_ref_hold <= ref_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_OFF;
         r_target   <= 1'b0;
         r_dead_cnt <= '0;
         gate_hi    <= 1'b0;
         gate_lo    <= 1'b0;
      end else if (!en) begin
         r_state <= S_OFF;
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
      end else begin
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
         case (r_state)
            S_OFF: begin
               r_state    <= S_DEAD;
               r_target   <= r_raw_q;
               r_dead_cnt <= DEAD_RELOAD;
            end
            S_DEAD: begin
               // Any raw change during dead time restarts the full interval.
               if (r_raw_q != r_target) begin
                  r_target   <= r_raw_q;
                  r_dead_cnt <= DEAD_RELOAD;
               end else if (r_dead_cnt == 8'd0) begin
                  r_state <= r_target ? S_HI : S_LO;
                  gate_hi <= r_target;
                  gate_lo <= !r_target;
               end else begin
                  r_dead_cnt <= r_dead_cnt - 8'd1;
               end
            end
            S_HI: begin
               if (!r_raw_q) begin
                  r_state    <= S_DEAD;
                  r_target   <= 1'b0;
                  r_dead_cnt <= DEAD_RELOAD;
               end else begin
                  gate_hi <= 1'b1;
               end
            end
            S_LO: begin
               if (r_raw_q) begin
                  r_state    <= S_DEAD;
                  r_target   <= 1'b1;
                  r_dead_cnt <= DEAD_RELOAD;
               end else begin
                  gate_lo <= 1'b1;
               end
            end
            default: begin
               r_state <= S_OFF;
            end
         endcase
      end
   end

endmodule
